// File: rtl/output_delta_unit_if.sv
// Group stream into and out of the output-layer delta unit.
// Both sides use valid/ready: a beat moves on the cycle valid && ready, and the
// sender holds valid and its payload stable until that cycle.
interface output_delta_unit_if #(
    parameter int width = 16,
    parameter int lanes = 2,
    parameter int lbl_w = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic [width*lanes-1:0]   a_package;
    logic [width*lanes-1:0]   sp_package;
    logic [lbl_w-1:0]         y_label;
    logic [width*lanes-1:0]   deltan_package;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic [lbl_w-1:0]         predict;
    logic                     correct;

    modport slave (
        input  in_valid, a_package, sp_package, y_label, out_ready,
        output in_ready, deltan_package, out_valid, out_last, predict, correct
    );

    modport master (
        output in_valid, a_package, sp_package, y_label, out_ready,
        input  in_ready, deltan_package, out_valid, out_last, predict, correct
    );
endinterface

// File: rtl/output_delta_unit.sv
// Output-layer delta: delta = sat(sat(a - y) * sp >>> frac_bits) per lane, plus
// a running argmax over each sample that yields predict/correct on its last group.
module output_delta_unit #(
    parameter int n         = 8,
    parameter int z         = 8,
    parameter int fi        = 4,
    parameter int width     = 16,
    parameter int int_bits  = 5,
    parameter int frac_bits = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    output_delta_unit_if.slave   bus
);
    localparam int L  = z / fi;
    localparam int G  = n * fi / z;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int LW = (n > 1) ? $clog2(n) : 1;

    localparam logic [GW-1:0] G_LAST = GW'(G - 1);
    localparam logic signed [width:0] Y_ONE =
        {{(width - frac_bits){1'b0}}, 1'b1, {frac_bits{1'b0}}};
    localparam logic signed [width:0] D_MAX = {2'b00, {(width-1){1'b1}}};
    localparam logic signed [width:0] D_MIN = {2'b11, {(width-1){1'b0}}};
    localparam logic signed [2*width-1:0] P_MAX = {{(width+1){1'b0}}, {(width-1){1'b1}}};
    localparam logic signed [2*width-1:0] P_MIN = {{(width+1){1'b1}}, {(width-1){1'b0}}};

    if ((G < 1) || (n * fi % z != 0) || (1 + int_bits + frac_bits != width)) begin : g_param_check
        $error("output_delta_unit: illegal parameter set");
    end

    function automatic logic [width-1:0] lane_delta(
        input logic signed [width-1:0] a,
        input logic signed [width-1:0] sp,
        input logic                    is_lbl
    );
        logic signed [width:0]     diff;
        logic signed [width-1:0]   diff_s;
        logic signed [2*width-1:0] prod;
        diff = $signed({a[width-1], a}) - (is_lbl ? Y_ONE : '0);
        if (diff > D_MAX)      diff_s = {1'b0, {(width-1){1'b1}}};
        else if (diff < D_MIN) diff_s = {1'b1, {(width-1){1'b0}}};
        else                   diff_s = diff[width-1:0];
        prod = diff_s * sp;
        prod = prod >>> frac_bits;
        if (prod > P_MAX)      lane_delta = {1'b0, {(width-1){1'b1}}};
        else if (prod < P_MIN) lane_delta = {1'b1, {(width-1){1'b0}}};
        else                   lane_delta = prod[width-1:0];
    endfunction

    logic [GW-1:0]            g_q;
    logic [LW-1:0]            lbl_q, lbl_eff;
    logic signed [width-1:0]  max_q, best_val;
    logic [LW-1:0]            idx_q, best_idx;
    logic                     out_valid_q, out_last_q, correct_q;
    logic [LW-1:0]            predict_q;
    logic [width*L-1:0]       deltan_q, deltan_c;
    logic                     accept, first, last;

    assign first  = (g_q == '0);
    assign last   = (g_q == G_LAST);
    assign accept = bus.in_valid && bus.in_ready;

    // Group 0 uses the label on the wire and restarts the argmax from lane 0.
    always_comb begin
        lbl_eff  = first ? bus.y_label : lbl_q;
        best_val = first ? $signed(bus.a_package[width-1:0]) : max_q;
        best_idx = first ? '0 : idx_q;
        deltan_c = '0;
        for (int k = 0; k < L; k++) begin
            if ($signed(bus.a_package[k*width +: width]) > best_val) begin
                best_val = $signed(bus.a_package[k*width +: width]);
                best_idx = LW'(int'(g_q) * L + k);
            end
            deltan_c[k*width +: width] = lane_delta(
                $signed(bus.a_package[k*width +: width]),
                $signed(bus.sp_package[k*width +: width]),
                LW'(int'(g_q) * L + k) == lbl_eff);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g_q         <= '0;
            lbl_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            deltan_q    <= '0;
            predict_q   <= '0;
            correct_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_last_q  <= last;
            deltan_q    <= deltan_c;
            g_q         <= last ? '0 : g_q + 1'b1;
            max_q       <= best_val;
            idx_q       <= best_idx;
            if (first) lbl_q <= bus.y_label;
            if (last) begin
                predict_q <= best_idx;
                correct_q <= (best_idx == lbl_eff);
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready       = !out_valid_q || bus.out_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_last       = out_last_q;
    assign bus.deltan_package = deltan_q;
    assign bus.predict        = predict_q;
    assign bus.correct        = correct_q;
endmodule

// File: tb/tb_output_delta_unit.sv
// Bench for output_delta_unit: directed steps plus random traffic against an
// integer reference model with an expected-output queue.
module tb_output_delta_unit;
  localparam int N  = 4;
  localparam int Z  = 4;
  localparam int FI = 2;
  localparam int W  = 16;
  localparam int IB = 5;
  localparam int FB = 10;
  localparam int L  = Z / FI;
  localparam int G  = N * FI / Z;
  localparam int LW = 2;
  localparam int DW = W * L;
  localparam int SW = 1 + DW + LW + 1;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_delta_unit_if #(.width(W), .lanes(L), .lbl_w(LW)) bus ();

  output_delta_unit #(
    .n(N), .z(Z), .fi(FI), .width(W), .int_bits(IB), .frac_bits(FB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // scoreboard / model state: {last, deltan, predict, correct}
  logic [SW-1:0] exp_q[$];
  int            mg;
  logic [LW-1:0] mlabel;
  int            sample_a[N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input int l0, input int l1);
    logic [W-1:0] x0, x1;
    x0 = W'(l0);
    x1 = W'(l1);
    return {x1, x0};
  endfunction

  function automatic logic [W-1:0] delta_model(input int a, input int sp, input bit is_lbl);
    longint diff, p;
    diff = longint'(a) - (is_lbl ? (longint'(1) << FB) : 0);
    if (diff > MAXV) diff = MAXV;
    if (diff < MINV) diff = MINV;
    p = (diff * sp) >>> FB;
    if (p > MAXV) p = MAXV;
    if (p < MINV) p = MINV;
    return W'(p);
  endfunction

  task automatic model_accept(input logic [DW-1:0] a, input logic [DW-1:0] sp,
                              input logic [LW-1:0] lbl);
    logic [DW-1:0] d;
    logic [LW-1:0] pred;
    bit last, corr;
    int best, idx, av, sv;
    if (mg == 0) mlabel = lbl;
    for (int k = 0; k < L; k++) begin
      av = int'($signed(a[k*W +: W]));
      sv = int'($signed(sp[k*W +: W]));
      idx = mg * L + k;
      sample_a[idx] = av;
      d[k*W +: W] = delta_model(av, sv, idx == int'(mlabel));
    end
    last = (mg == G - 1);
    pred = '0;
    corr = 1'b0;
    if (last) begin
      best = 0;
      for (int i = 1; i < N; i++) if (sample_a[i] > sample_a[best]) best = i;
      pred = LW'(best);
      corr = (pred == mlabel);
    end
    exp_q.push_back({last, d, pred, corr});
    mg = (mg + 1) % G;
  endtask

  // driver: one clock cycle of stimulus, checked against the model
  task automatic cycle(input bit iv, input logic [DW-1:0] a, input logic [DW-1:0] sp,
                       input logic [LW-1:0] lbl, input bit ordy);
    logic [SW-1:0] head;
    bit exp_valid, exp_ready;
    bus.in_valid = iv;
    bus.a_package = a;
    bus.sp_package = sp;
    bus.y_label = lbl;
    bus.out_ready = ordy;
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_ready = !exp_valid || ordy;
    chk("out_valid", bus.out_valid, exp_valid);
    chk("in_ready", bus.in_ready, exp_ready);
    if (exp_valid) begin
      head = exp_q[0];
      chk("deltan", bus.deltan_package, head[SW-2 -: DW]);
      chk("out_last", bus.out_last, head[SW-1]);
      if (head[SW-1]) begin
        chk("predict", bus.predict, head[LW:1]);
        chk("correct", bus.correct, head[0]);
      end
      if (ordy) void'(exp_q.pop_front());
    end
    if (iv && exp_ready) model_accept(a, sp, lbl);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_pkg();
    logic [DW-1:0] v;
    for (int k = 0; k < L; k++)
      v[k*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
    return v;
  endfunction

  initial begin
    mg = 0;
    mlabel = '0;
    for (int i = 0; i < N; i++) sample_a[i] = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_package = '0;
    bus.sp_package = '0;
    bus.y_label = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_deltan", bus.deltan_package, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_predict", bus.predict, 0);
    chk("rst_correct", bus.correct, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // basic delta, label lane vs other lane
    cycle(1, pk(768, 768), pk(192, 192), 1, 1);
    chk("basic_deltan", bus.deltan_package, pk(144, -48));
    chk("basic_last", bus.out_last, 0);
    cycle(1, pk(10, 20), pk(100, 100), 0, 1);
    chk("basic_last1", bus.out_last, 1);
    chk("basic_predict", bus.predict, 0);
    chk("basic_correct", bus.correct, 0);

    // backpressure: outputs frozen, no accept until out_ready
    cycle(1, pk(50, 60), pk(300, 300), 2, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, pk(70, 80), pk(300, 300), 0, 0);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_deltan", bus.deltan_package, pk(14, 17));
      chk("stall_last", bus.out_last, 0);
    end
    cycle(1, pk(70, 80), pk(300, 300), 0, 1);
    chk("stall_release_last", bus.out_last, 1);
    chk("stall_release_deltan", bus.deltan_package, pk(-280, 23));
    chk("stall_release_predict", bus.predict, 3);

    // argmax tie keeps lower index
    cycle(1, pk(100, 300), pk(1024, 1024), 2, 1);
    cycle(1, pk(300, 50), pk(1024, 1024), 0, 1);
    chk("tie_predict", bus.predict, 1);
    chk("tie_correct", bus.correct, 0);
    chk("tie_last", bus.out_last, 1);

    // saturation at both ends
    cycle(1, pk(-32768, 32767), pk(32767, 32767), 0, 1);
    chk("sat_deltan", bus.deltan_package, {16'h7FFF, 16'h8000});
    cycle(1, pk(0, 0), pk(0, 0), 0, 1);

    // reset in mid-sample
    cycle(1, pk(400, 400), pk(500, 500), 1, 1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_deltan", bus.deltan_package, 0);
    chk("mid_rst_last", bus.out_last, 0);
    exp_q.delete();
    mg = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1, pk(5, 5), pk(1000, 1000), 3, 1);
    chk("post_rst_first", bus.out_last, 0);
    cycle(1, pk(1, 900), pk(1000, 1000), 0, 1);
    chk("post_rst_last", bus.out_last, 1);
    chk("post_rst_predict", bus.predict, 3);
    chk("post_rst_correct", bus.correct, 1);

    // full throughput
    for (int i = 0; i < 2 * G * 2; i++) begin
      cycle(1, rnd_pkg(), rnd_pkg(), LW'($urandom_range(0, N - 1)), 1);
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_last", bus.out_last, (i % G) == G - 1);
    end

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rnd_pkg(), rnd_pkg(),
            LW'($urandom_range(0, N - 1)), $urandom_range(0, 3) != 0);

    // drain with a bounded budget
    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      cycle(0, '0, '0, '0, 1);
    chk("drain_empty", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/output_delta_unit.md
OUTPUT_DELTA_UNIT -- requirements
Module: output_delta_unit

Interface
REQ-001 SHALL have parameter n, default 8: neurons in the output layer.
REQ-002 SHALL have parameter z, default 8: total weight lanes per cycle.
REQ-003 SHALL have parameter fi, default 4: fan-in.
REQ-004 SHALL define G = n*fi/z, the number of groups per sample, which SHALL be an integer of at least 1.
REQ-005 SHALL have parameter width, default 16.
REQ-006 SHALL have parameter int_bits, default 5.
REQ-007 SHALL have parameter frac_bits, default 10: two's-complement fixed point.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port in_valid, input, 1 bit: an input group is presented.
REQ-011 SHALL have port in_ready, output, 1 bit: the unit accepts the group this cycle.
REQ-012 SHALL have port a_package, input, width*z/fi bits: actn values of the current group, lane k = neuron g*(z/fi)+k.
REQ-013 SHALL have port sp_package, input, width*z/fi bits: sigmoid-prime values, same lane order.
REQ-014 SHALL have port y_label, input, clog2(n) bits: ideal-class index, sampled only on group 0.
REQ-015 SHALL have port deltan_package, output, width*z/fi bits: output-layer deltas, same lane order.
REQ-016 SHALL have port out_valid, output, 1 bit: deltan_package is valid.
REQ-017 SHALL have port out_ready, input, 1 bit: downstream BP accepts.
REQ-018 SHALL have port out_last, output, 1 bit: the current output is group G-1 of a sample.
REQ-019 SHALL have port predict, output, clog2(n) bits: argmax neuron index of the completed sample.
REQ-020 SHALL have port correct, output, 1 bit: predict equals the latched label; meaningful only while out_valid&&out_last.

Function
REQ-021 SHALL accept an input group on the cycle in_valid&&in_ready, and SHALL transfer an output group on the cycle out_valid&&out_ready.
REQ-022 SHALL drive in_ready = !out_valid || out_ready combinationally, giving a single output register stage with no bubble under full throughput.
REQ-023 SHALL present the result of an accepted group on the next cycle with out_valid=1 (latency 1).
REQ-024 SHALL hold deltan_package, out_last, predict and correct stable while out_valid&&!out_ready.
REQ-025 SHALL keep a group counter g in 0..G-1 that increments on each accept and wraps from G-1 to 0.
REQ-026 SHALL set out_last when the accepted group had g == G-1.
REQ-027 SHALL treat every group as both first and last when G == 1.
REQ-028 SHALL register y_label on acceptance of group 0 and SHALL use that registered label for all later groups; for group 0 itself the label input is used directly.
REQ-029 SHALL compute, per lane, y = 1<<frac_bits when the neuron index equals the label, and y = 0 otherwise.
REQ-030 SHALL compute diff = a - y at width+1 bits, then saturate it to width bits (min 0x8000 / max 0x7FFF for width 16).
REQ-031 SHALL compute delta = (diff*sp) as a 2*width-bit product, arithmetic-shifted right by frac_bits, then saturated to width bits.
REQ-032 SHALL track a running argmax of a over the sample, reinitialised at group 0.
REQ-033 SHALL let the argmax update only on a strictly greater value (signed compare), so ties keep the lower neuron index, lanes being scanned in ascending order.
REQ-034 SHALL update predict and correct only when the last group is accepted, and hold them until the next last-group accept.

Reset
REQ-035 SHALL, while reset=1 asynchronously, clear out_valid, out_last, deltan_package, predict, correct, the group counter, the latched label and the argmax state to 0.
REQ-036 SHALL drive in_ready = 1 while reset is asserted and immediately after its release.
REQ-037 SHALL discard any partial sample on reset mid-sample; the first group accepted after reset is group 0.

Verification
(Parameters for all scenarios: width=16, frac_bits=10, z/fi=2, n=4, G=2.)
REQ-038 SHALL be verified by: group 0, label=1, a={768,768}, sp={192,192} -> next cycle deltan lane0=144 (0x0090), lane1=-48 (0xFFD0), out_last=0.
REQ-039 SHALL be verified by: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, counter unchanged; out_ready=1 -> transfer, and the next group is accepted the same cycle.
REQ-040 SHALL be verified by: sample a={100,300},{300,50}, label=2 -> on the last output predict=1 (tie resolved to lower index), correct=0, out_last=1.
REQ-041 SHALL be verified by: a=0x8000, label lane, sp=0x7FFF -> diff saturates to 0x8000 and delta saturates to 0x8000; a=0x7FFF, non-label, sp=0x7FFF -> delta=0x7FFF.
REQ-042 SHALL be verified by: reset pulsed after group 0 accepted -> all outputs 0 and in_ready=1; the next accept is treated as group 0 and its y_label is latched.
REQ-043 SHALL be verified by: continuous in_valid=1 and out_ready=1 for 4 samples -> one output per cycle and out_last on every second output.
